// File: rtl/rv32_pkg.sv
// Shared fetch-stage types: FSM states, NOP encoding and instruction buffer entry layout.
package rv32_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small instruction FIFO between fetch and decode; flush empties it in one cycle.
module fetch_buf
  import rv32_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         valid,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requests feeding a small buffer toward decode.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_INST = NOP,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_misalign,
  input  logic        id_ready
);

  localparam int unsigned    CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0]  DEPTH_M1 = CW'(BUF_DEPTH - 1);

  fetch_state_t  state;
  logic          drop;
  logic          fault;
  logic [31:0]   req_pc;
  logic          misalign_pc;
  logic          pop;
  logic          push;
  fetch_entry_t  push_entry;
  logic          buf_valid;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          room_after;

  assign misalign_pc = (pc_in[1:0] != 2'b00);
  assign imem_req    = (state == REQ) && !misalign_pc;
  assign imem_addr   = imem_req ? {pc_in[31:2], 2'b00} : '0;
  assign pc_hold     = ~(imem_req & imem_gnt) & ~flush;
  assign pop         = buf_valid & id_ready;
  assign room_after  = (count < DEPTH_M1) || pop;

  always_comb begin
    push       = 1'b0;
    push_entry = '{pc: pc_in, inst: RESET_INST, misalign: 1'b1};
    if (!flush) begin
      if (state == REQ && misalign_pc) begin
        push = 1'b1;
      end else if (state == WAIT && imem_rvalid && !drop) begin
        push       = 1'b1;
        push_entry = '{pc: req_pc, inst: imem_rdata, misalign: 1'b0};
      end
    end
  end

  // fault parks the FSM after a misaligned entry until the PC stage is redirected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      drop   <= 1'b0;
      fault  <= 1'b0;
      req_pc <= '0;
    end else begin
      if (flush) fault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!flush && !fault && (count < DEPTH_C)) state <= REQ;
        end
        REQ: begin
          if (imem_req && imem_gnt) begin
            req_pc <= pc_in;
            drop   <= flush;
            state  <= WAIT;
          end else if (misalign_pc && !flush) begin
            fault <= 1'b1;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (flush || drop || room_after) state <= REQ;
            else                             state <= IDLE;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .valid      (buf_valid),
    .head       (head),
    .count      (count)
  );

  assign inst_valid    = buf_valid;
  assign inst          = buf_valid ? head.inst : RESET_INST;
  assign inst_pc       = buf_valid ? head.pc : '0;
  assign inst_misalign = buf_valid & head.misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC stage and memory modelled here, decode stream checked against address order.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RINST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misalign;
  logic        id_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_INST(RINST), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .pc_hold(pc_hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_misalign(inst_misalign), .id_ready(id_ready)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  // environment: PC stage, memory responder, decode-side expectation
  logic [31:0] pc = '0, exp_pc = '0, resp_addr = '0, tgt = '0;
  logic        resp_pending = 1'b0, resp_stale = 1'b0, exp_halt = 1'b0;
  int unsigned resp_delay = 0, gnt_mode = 0, lat_min = 1, lat_max = 1;
  int unsigned n_gnt = 0, n_consumed = 0;
  logic        fl = 1'b0, rdy = 1'b0, stray = 1'b0;
  logic        prev_hold = 1'b0, prev_mis = 1'b0;
  logic [31:0] prev_pc = '0, prev_inst = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  task automatic tick();
    logic        e_mis;
    logic [31:0] e_inst;
    logic        resp_now;
    pc_in = pc;
    case (gnt_mode)
      0:       imem_gnt = 1'b0;
      1:       imem_gnt = 1'b1;
      default: imem_gnt = 1'($urandom_range(0, 1));
    endcase
    resp_now    = resp_pending && (resp_delay == 0);
    imem_rvalid = resp_now || stray;
    imem_rdata  = resp_now ? mem_word(resp_addr) : $urandom();
    flush       = fl;
    id_ready    = rdy;
    #1;
    if (imem_req) begin
      checks++;
      if (imem_addr !== {pc[31:2], 2'b00})
        $display("FAIL imem_addr got %h want %h", imem_addr, {pc[31:2], 2'b00});
      else passes++;
    end
    checks++;
    if (imem_req === 1'b1 && pc[1:0] != 2'b00)
      $display("FAIL req_on_misaligned pc %h got imem_req 1 want 0", pc);
    else passes++;
    checks++;
    if (imem_req && imem_gnt && resp_pending && !resp_stale)
      $display("FAIL second_outstanding got grant while %h pending want none", resp_addr);
    else passes++;
    checks++;
    if (pc_hold !== (~(imem_req & imem_gnt) & ~fl))
      $display("FAIL pc_hold got %b want %b", pc_hold, ~(imem_req & imem_gnt) & ~fl);
    else passes++;
    if (inst_valid !== 1'b1) begin
      checks++;
      if (inst !== RINST) $display("FAIL idle_inst got %h want %h", inst, RINST);
      else passes++;
    end
    if (prev_hold) begin
      checks++;
      if ({inst_valid, inst_pc, inst, inst_misalign} !== {1'b1, prev_pc, prev_inst, prev_mis})
        $display("FAIL stall_stable got %b/%h/%h/%b want 1/%h/%h/%b", inst_valid, inst_pc,
                 inst, inst_misalign, prev_pc, prev_inst, prev_mis);
      else passes++;
    end
    if (exp_halt) begin
      checks++;
      if (inst_valid !== 1'b0) $display("FAIL after_fault_valid got %b want 0", inst_valid);
      else passes++;
    end
    if (inst_valid && rdy && !fl) begin
      e_mis  = (exp_pc[1:0] != 2'b00);
      e_inst = e_mis ? RINST : mem_word(exp_pc);
      checks++;
      if ({inst_pc, inst, inst_misalign} !== {exp_pc, e_inst, e_mis})
        $display("FAIL stream got pc %h inst %h mis %b want pc %h inst %h mis %b",
                 inst_pc, inst, inst_misalign, exp_pc, e_inst, e_mis);
      else passes++;
      n_consumed++;
      if (e_mis) exp_halt = 1'b1;
      else exp_pc = exp_pc + 32'd4;
    end
    prev_hold = inst_valid && !rdy && !fl;
    prev_pc   = inst_pc;
    prev_inst = inst;
    prev_mis  = inst_misalign;
    if (resp_now) begin
      resp_pending = 1'b0;
      resp_stale   = 1'b0;
    end else if (resp_pending && resp_delay > 0) begin
      resp_delay--;
    end
    if (imem_req && imem_gnt) begin
      resp_pending = 1'b1;
      resp_stale   = 1'b0;
      resp_addr    = imem_addr;
      resp_delay   = $urandom_range(lat_max - 1, lat_min - 1);
      n_gnt++;
    end
    if (fl) begin
      pc       = tgt;
      exp_pc   = tgt;
      exp_halt = 1'b0;
    end else if (!pc_hold) begin
      pc = pc + 32'd4;
    end
    stray = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] target);
    tgt = target;
    fl  = 1'b1;
    tick();
    fl = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({imem_req, imem_addr} !== 33'd0) $display("FAIL rst_req got %b/%h want 0/0", imem_req, imem_addr);
    else passes++;
    checks++;
    if ({inst_valid, inst, inst_pc, inst_misalign} !== {1'b0, RINST, 32'd0, 1'b0})
      $display("FAIL rst_inst got %b/%h/%h/%b want 0/%h/0/0", inst_valid, inst, inst_pc, inst_misalign, RINST);
    else passes++;
    checks++;
    if (pc_hold !== 1'b1) $display("FAIL rst_pc_hold got %b want 1", pc_hold);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) $display("FAIL release_req got %b want 0", imem_req);
    else passes++;
    gnt_mode = 0;
    tick();
    checks++;
    if (imem_req !== 1'b1) $display("FAIL first_req got %b want 1 after one edge", imem_req);
    else passes++;
  endtask

  task automatic test_stream();
    int unsigned k = 0;
    gnt_mode = 1; lat_min = 1; lat_max = 1; rdy = 1'b1;
    for (int i = 0; i < 30 && k < 3; i++) begin
      if (inst_valid) begin
        checks++;
        if ({inst_pc, inst} !== {32'(4 * k), mem_word(32'(4 * k))})
          $display("FAIL stream_start got %h/%h want %h/%h", inst_pc, inst, 32'(4 * k), mem_word(32'(4 * k)));
        else passes++;
        k++;
      end
      tick();
    end
    checks++;
    if (k != 3) $display("FAIL stream_count got %0d want 3", k);
    else passes++;
  endtask

  task automatic test_backpressure();
    int unsigned base;
    gnt_mode = 1; lat_min = 1; lat_max = 1; rdy = 1'b0;
    redirect(32'h200);
    n_gnt = 0;
    repeat (20) tick();
    checks++;
    if (n_gnt != DEPTH) $display("FAIL bp_grants got %0d want %0d", n_gnt, DEPTH);
    else passes++;
    checks++;
    if ({inst_valid, inst_pc, imem_req, pc_hold} !== {1'b1, 32'h200, 1'b0, 1'b1})
      $display("FAIL bp_state got %b/%h/%b/%b want 1/200/0/1", inst_valid, inst_pc, imem_req, pc_hold);
    else passes++;
    checks++;
    if (pc !== 32'h208) $display("FAIL bp_pc got %h want 208", pc);
    else passes++;
    rdy  = 1'b1;
    base = n_consumed;
    for (int i = 0; i < 40 && n_consumed < base + 3; i++) tick();
    checks++;
    if (n_consumed < base + 3) $display("FAIL bp_resume got %0d want %0d", n_consumed - base, 3);
    else passes++;
  endtask

  task automatic test_flush_wait();
    int unsigned i;
    gnt_mode = 1; lat_min = 3; lat_max = 3; rdy = 1'b1;
    redirect(32'h10);
    for (i = 0; i < 40; i++) begin
      if (resp_pending && !resp_stale && resp_addr == 32'h10 && resp_delay > 0) break;
      tick();
    end
    checks++;
    if (i == 40) $display("FAIL fw_reach got timeout want wait at 10");
    else passes++;
    redirect(32'h100);
    for (i = 0; i < 40 && !inst_valid; i++) tick();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, mem_word(32'h100)})
      $display("FAIL fw_target got %b/%h/%h want 1/100/%h", inst_valid, inst_pc, inst, mem_word(32'h100));
    else passes++;
  endtask

  task automatic test_flush_pop();
    int unsigned i;
    gnt_mode = 1; lat_min = 1; lat_max = 1; rdy = 1'b0;
    redirect(32'h300);
    for (i = 0; i < 30; i++) begin
      if (inst_valid && resp_pending && resp_delay == 0) break;
      tick();
    end
    checks++;
    if (i == 30) $display("FAIL fp_reach got timeout want valid with rvalid due");
    else passes++;
    rdy = 1'b1;
    redirect(32'h400);
    rdy = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) $display("FAIL fp_empty got %b want 0", inst_valid);
    else passes++;
    rdy = 1'b1;
    for (i = 0; i < 30 && !inst_valid; i++) tick();
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h400}) $display("FAIL fp_target got %b/%h want 1/400", inst_valid, inst_pc);
    else passes++;
  endtask

  task automatic test_misalign();
    gnt_mode = 1; lat_min = 1; lat_max = 2; rdy = 1'b0;
    redirect(32'h102);
    n_gnt = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    checks++;
    if ({inst_valid, inst_misalign, inst, inst_pc} !== {1'b1, 1'b1, RINST, 32'h102})
      $display("FAIL mis_entry got %b/%b/%h/%h want 1/1/%h/102", inst_valid, inst_misalign, inst, inst_pc, RINST);
    else passes++;
    checks++;
    if (n_gnt != 0) $display("FAIL mis_grants got %0d want 0", n_gnt);
    else passes++;
    rdy = 1'b1;
    repeat (6) tick();
    checks++;
    if ({inst_valid, imem_req, pc_hold, pc} !== {1'b0, 1'b0, 1'b1, 32'h102})
      $display("FAIL mis_parked got %b/%b/%b/%h want 0/0/1/102", inst_valid, imem_req, pc_hold, pc);
    else passes++;
    redirect(32'h500);
  endtask

  task automatic test_reset_wait();
    int unsigned i;
    gnt_mode = 1; lat_min = 6; lat_max = 6; rdy = 1'b1;
    redirect(32'h600);
    for (i = 0; i < 40; i++) begin
      if (resp_pending && !resp_stale && resp_delay >= 3) break;
      tick();
    end
    checks++;
    if (i == 40) $display("FAIL rw_reach got timeout want wait state");
    else passes++;
    gnt_mode   = 0;
    reset      = 1'b0;
    resp_stale = 1'b1;
    tick();
    reset     = 1'b1;
    exp_pc    = pc;
    exp_halt  = 1'b0;
    prev_hold = 1'b0;
    for (i = 0; i < 12 && resp_pending; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b0) $display("FAIL rw_stray got %b want 0", inst_valid);
      else passes++;
    end
    stray = 1'b1;
    tick();
    tick();
    checks++;
    if (inst_valid !== 1'b0) $display("FAIL stray_rvalid got %b want 0", inst_valid);
    else passes++;
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    i = n_consumed;
    for (int j = 0; j < 30 && n_consumed < i + 2; j++) tick();
    checks++;
    if (n_consumed < i + 2) $display("FAIL rw_resume got %0d want 2", n_consumed - i);
    else passes++;
  endtask

  task automatic test_random();
    int unsigned base = n_consumed;
    gnt_mode = 2; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt = $urandom() & 32'h000F_FFFC;
        if ($urandom_range(0, 7) == 0) tgt = tgt | 32'd2;
        fl = 1'b1;
      end
      tick();
      fl = 1'b0;
    end
    checks++;
    if (n_consumed < base + 200) $display("FAIL rand_progress got %0d want >= 200", n_consumed - base);
    else passes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_wait();
    test_flush_pop();
    test_misalign();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
